edge_synth: RTL and testbench
=============================

EDGE_SYNTH -- requirements
Module: edge_synth

Interface
REQ-001 Parameter MIN_HIGH, default 4: minimum cycles level_o stays 1 after a rising edge; legal range 1..255.
REQ-002 Parameter MIN_LOW, default 4: minimum cycles level_o stays 0 after a falling edge; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rise_req_i  input  1  request to drive level_o 0->1; held until accepted.
REQ-006 fall_req_i  input  1  request to drive level_o 1->0; held until accepted.
REQ-007 req_ready_o  output  1  block can accept a request this cycle.
REQ-008 level_o  output  1  synthesized registered level.
REQ-009 busy_o  output  1  minimum-width hold in progress.
REQ-010 err_o  output  1  sticky protocol-error flag.
REQ-011 err_clr_i  input  1  synchronous clear of err_o.
REQ-012 edge_cnt_o  output  8  count of applied edges, both directions.

Function
REQ-013 Four states SHALL exist: LOW_IDLE, HIGH_HOLD, HIGH_IDLE, LOW_HOLD.
REQ-014 req_ready_o SHALL be 1 exactly in LOW_IDLE and HIGH_IDLE, decoded from state with no input dependency.
REQ-015 busy_o SHALL be 1 exactly in HIGH_HOLD and LOW_HOLD.
REQ-016 Accept = request high AND req_ready_o high in the same cycle; a request present while not ready SHALL be ignored without error.
REQ-017 In LOW_IDLE, an accepted rise_req_i alone SHALL set level_o=1 on the next edge, enter HIGH_HOLD, and load the hold counter with MIN_HIGH-1.
REQ-018 In HIGH_IDLE, an accepted fall_req_i alone SHALL set level_o=0 on the next edge, enter LOW_HOLD, and load the hold counter with MIN_LOW-1.
REQ-019 In a HOLD state with counter nonzero, the counter SHALL decrement by 1; at 0 the FSM SHALL move to the matching IDLE state (HIGH_HOLD->HIGH_IDLE, LOW_HOLD->LOW_IDLE).
REQ-020 Latency SHALL be 1 cycle from accept to level_o change.
REQ-021 level_o SHALL remain stable for at least MIN_HIGH or MIN_LOW cycles after each change.
REQ-022 MIN_x=1 SHALL yield a 1-cycle HOLD, so a new request can be accepted 1 cycle after the edge.
REQ-023 A redundant request while ready (rise in HIGH_IDLE, fall in LOW_IDLE) SHALL set err_o and leave level_o, state and edge_cnt_o unchanged.
REQ-024 rise_req_i and fall_req_i both high while ready SHALL set err_o, with no edge applied.
REQ-025 err_o SHALL clear on err_clr_i; if an error event coincides with err_clr_i, set SHALL win.
REQ-026 edge_cnt_o SHALL increment on every applied edge and wrap 255->0.

Reset
REQ-027 Asserting reset SHALL immediately force state LOW_IDLE, level_o=0, hold counter=0, err_o=0, edge_cnt_o=0.
REQ-028 Reset asserted mid-HOLD SHALL abort the hold, and level_o SHALL read 0 while reset is low.
REQ-029 After reset deasserts, req_ready_o SHALL be 1 from the first clock.

Structure
REQ-030 Package edge_synth_pkg SHALL hold the state enumeration and the counter-width constant HOLD_W=8.
REQ-031 Sub-module hold_timer SHALL implement the loadable down-counter (load, value, zero flag); the FSM stays in edge_synth.

Verification
REQ-032 Reset, then rise_req_i held 1 cycle with MIN_HIGH=4 -> level_o=1 next cycle, busy_o=1 for 4 cycles, then req_ready_o=1; edge_cnt_o=1.
REQ-033 fall_req_i held high from the cycle after a rise, MIN_HIGH=4 -> fall accepted only when HIGH_IDLE is reached; level_o high exactly 5 cycles (4 hold plus 1 idle accept cycle); err_o=0.
REQ-034 rise_req_i in HIGH_IDLE -> err_o=1, level_o stays 1, edge_cnt_o unchanged; err_clr_i then clears err_o; err_clr_i coinciding with a new error -> err_o stays 1.
REQ-035 rise_req_i and fall_req_i both 1 in LOW_IDLE -> err_o=1, level_o=0, state stays LOW_IDLE.
REQ-036 reset asserted at hold count 2 of HIGH_HOLD -> level_o=0 asynchronously; after release, req_ready_o=1 and edge_cnt_o=0.
REQ-037 MIN_HIGH=MIN_LOW=1 with alternating requests for 256 edges -> level_o toggles every 2 cycles; edge_cnt_o wraps to 0.

Source files
------------

// File: rtl/edge_synth_pkg.sv
// Shared types and constants for the edge synthesizer: FSM state encoding
// and the hold-counter width.
package edge_synth_pkg;

  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    HIGH_HOLD = 2'd1,
    HIGH_IDLE = 2'd2,
    LOW_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/edge_synth_hold_timer.sv
// Loadable down-counter timing the minimum-width hold; stops at zero and
// flags it so the FSM can leave the hold state.
module hold_timer
  import edge_synth_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_value,
  input  logic              dec,
  output logic              zero
);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/edge_synth.sv
// Synthesizes a registered level from rise/fall requests, enforcing a minimum
// high and low width and flagging redundant or conflicting requests.
module edge_synth
  import edge_synth_pkg::*;
#(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rise_req_i,
  input  logic       fall_req_i,
  input  logic       err_clr_i,
  output logic       req_ready_o,
  output logic       level_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [7:0] edge_cnt_o,
  output state_e     dbg_state
);

  // Handshake: a request is accepted in any cycle where it is high and
  // req_ready_o is high; requests seen while not ready are simply ignored.
  localparam logic [HOLD_W-1:0] HIGH_LOAD = HOLD_W'(MIN_HIGH - 1);
  localparam logic [HOLD_W-1:0] LOW_LOAD  = HOLD_W'(MIN_LOW - 1);

  state_e            state, state_n;
  logic              level_n;
  logic              load;
  logic [HOLD_W-1:0] load_value;
  logic              dec;
  logic              apply;
  logic              err_set;
  logic              zero;

  hold_timer u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .dec        (dec),
    .zero       (zero)
  );

  assign req_ready_o = (state == LOW_IDLE) || (state == HIGH_IDLE);
  assign busy_o      = (state == HIGH_HOLD) || (state == LOW_HOLD);
  assign dbg_state   = state;

  always_comb begin
    state_n    = state;
    level_n    = level_o;
    load       = 1'b0;
    load_value = HIGH_LOAD;
    dec        = 1'b0;
    apply      = 1'b0;
    err_set    = 1'b0;
    case (state)
      LOW_IDLE: begin
        // A fall request here is redundant, alone or paired with a rise.
        if (fall_req_i) begin
          err_set = 1'b1;
        end else if (rise_req_i) begin
          state_n    = HIGH_HOLD;
          level_n    = 1'b1;
          load       = 1'b1;
          load_value = HIGH_LOAD;
          apply      = 1'b1;
        end
      end
      HIGH_IDLE: begin
        if (rise_req_i) begin
          err_set = 1'b1;
        end else if (fall_req_i) begin
          state_n    = LOW_HOLD;
          level_n    = 1'b0;
          load       = 1'b1;
          load_value = LOW_LOAD;
          apply      = 1'b1;
        end
      end
      HIGH_HOLD: begin
        if (zero) state_n = HIGH_IDLE;
        else      dec     = 1'b1;
      end
      LOW_HOLD: begin
        if (zero) state_n = LOW_IDLE;
        else      dec     = 1'b1;
      end
      default: state_n = LOW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOW_IDLE;
      level_o    <= 1'b0;
      err_o      <= 1'b0;
      edge_cnt_o <= 8'd0;
    end else begin
      state   <= state_n;
      level_o <= level_n;
      if (err_set)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
      if (apply) edge_cnt_o <= edge_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_edge_synth.sv
// Scoreboard bench for edge_synth: directed steps push hand-computed expected
// outputs; a monitor pops and compares them at each falling clock edge.
module tb_edge_synth;
  import edge_synth_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic probe = 1'b0;

  logic rise = 1'b0, fall = 1'b0, clr = 1'b0;
  logic ready, level, busy, err;
  logic [7:0] cnt;
  state_e st;

  logic rise1 = 1'b0, fall1 = 1'b0, clr1 = 1'b0;
  logic ready1, level1, busy1, err1;
  logic [7:0] cnt1;
  state_e st1;

  logic [11:0] exp_q[$];
  logic [11:0] exp1_q[$];
  string       nm_q[$];
  string       nm1_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  edge_synth #(.MIN_HIGH(4), .MIN_LOW(4)) dut (
    .clk(clk), .reset(reset), .rise_req_i(rise), .fall_req_i(fall),
    .err_clr_i(clr), .req_ready_o(ready), .level_o(level), .busy_o(busy),
    .err_o(err), .edge_cnt_o(cnt), .dbg_state(st)
  );

  edge_synth #(.MIN_HIGH(1), .MIN_LOW(1)) dut1 (
    .clk(clk), .reset(reset), .rise_req_i(rise1), .fall_req_i(fall1),
    .err_clr_i(clr1), .req_ready_o(ready1), .level_o(level1), .busy_o(busy1),
    .err_o(err1), .edge_cnt_o(cnt1), .dbg_state(st1)
  );

  function automatic logic [11:0] mk(input logic l, input logic b, input logic r,
                                     input logic e, input logic [7:0] c);
    return {l, b, r, e, c};
  endfunction

  // Monitor: one observation per falling edge (or probe pulse) per queue.
  always @(negedge clk or posedge probe) begin
    logic [11:0] e, o;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      o  = {level, busy, ready, err, cnt};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got lvl/busy/rdy/err=%b cnt=%0d, expected lvl/busy/rdy/err=%b cnt=%0d",
                 nm, o[11:8], o[7:0], e[11:8], e[7:0]);
      end
    end
    if (exp1_q.size() > 0) begin
      e  = exp1_q.pop_front();
      nm = nm1_q.pop_front();
      o  = {level1, busy1, ready1, err1, cnt1};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got lvl/busy/rdy/err=%b cnt=%0d, expected lvl/busy/rdy/err=%b cnt=%0d",
                 nm, o[11:8], o[7:0], e[11:8], e[7:0]);
      end
    end
  end

  task automatic step(input logic r, input logic f, input logic c,
                      input logic [11:0] e, input string nm);
    rise = r; fall = f; clr = c;
    @(posedge clk);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    #1;
  endtask

  task automatic step1(input logic r, input logic f,
                       input logic [11:0] e, input string nm);
    rise1 = r; fall1 = f;
    @(posedge clk);
    exp1_q.push_back(e);
    nm1_q.push_back(nm);
    #1;
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, mk(0, 0, 1, 0, 8'd0), "reset_state");
    reset = 1'b1;

    // Rise with MIN_HIGH=4: four busy cycles then ready
    step(1, 0, 0, mk(1, 1, 0, 0, 8'd1), "rise_hold3");
    step(0, 0, 0, mk(1, 1, 0, 0, 8'd1), "rise_hold2");
    step(0, 0, 0, mk(1, 1, 0, 0, 8'd1), "rise_hold1");
    step(0, 0, 0, mk(1, 1, 0, 0, 8'd1), "rise_hold0");
    step(0, 0, 0, mk(1, 0, 1, 0, 8'd1), "high_idle");

    // Redundant rise, clear, and set-wins-over-clear
    step(1, 0, 0, mk(1, 0, 1, 1, 8'd1), "redundant_rise");
    step(0, 0, 1, mk(1, 0, 1, 0, 8'd1), "err_clear");
    step(1, 0, 1, mk(1, 0, 1, 1, 8'd1), "set_wins_clear");
    step(0, 0, 1, mk(1, 0, 1, 0, 8'd1), "err_clear2");

    // Fall with MIN_LOW=4
    step(0, 1, 0, mk(0, 1, 0, 0, 8'd2), "fall_hold3");
    step(0, 0, 0, mk(0, 1, 0, 0, 8'd2), "fall_hold2");
    step(0, 0, 0, mk(0, 1, 0, 0, 8'd2), "fall_hold1");
    step(0, 0, 0, mk(0, 1, 0, 0, 8'd2), "fall_hold0");
    step(0, 0, 0, mk(0, 0, 1, 0, 8'd2), "low_idle");

    // Conflicting and redundant requests in LOW_IDLE
    step(1, 1, 0, mk(0, 0, 1, 1, 8'd2), "both_req");
    step(0, 1, 1, mk(0, 0, 1, 1, 8'd2), "redundant_fall_clr");
    step(0, 0, 1, mk(0, 0, 1, 0, 8'd2), "err_clear3");

    // Fall held through the high hold: accepted only in HIGH_IDLE
    step(1, 0, 0, mk(1, 1, 0, 0, 8'd3), "rise2_hold3");
    step(0, 1, 0, mk(1, 1, 0, 0, 8'd3), "fall_ignored2");
    step(0, 1, 0, mk(1, 1, 0, 0, 8'd3), "fall_ignored1");
    step(0, 1, 0, mk(1, 1, 0, 0, 8'd3), "fall_ignored0");
    step(0, 1, 0, mk(1, 0, 1, 0, 8'd3), "high_idle_accept");
    step(0, 1, 0, mk(0, 1, 0, 0, 8'd4), "fall_after_5");
    step(0, 0, 0, mk(0, 1, 0, 0, 8'd4), "fall2_hold2");
    step(0, 0, 0, mk(0, 1, 0, 0, 8'd4), "fall2_hold1");
    step(0, 0, 0, mk(0, 1, 0, 0, 8'd4), "fall2_hold0");
    step(0, 0, 0, mk(0, 0, 1, 0, 8'd4), "low_idle2");

    // Asynchronous reset at hold count 2
    step(1, 0, 0, mk(1, 1, 0, 0, 8'd5), "rise3_hold3");
    step(0, 0, 0, mk(1, 1, 0, 0, 8'd5), "rise3_hold2");
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 1, 0, 8'd0));
    nm_q.push_back("async_reset");
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    step(0, 0, 0, mk(0, 0, 1, 0, 8'd0), "reset_held");
    reset = 1'b1;
    step(0, 0, 0, mk(0, 0, 1, 0, 8'd0), "after_release");
    step(1, 0, 0, mk(1, 1, 0, 0, 8'd1), "first_accept");

    // MIN_HIGH=MIN_LOW=1: 256 alternating edges, counter wraps
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) begin
        step1(1, 0, mk(1, 1, 0, 0, 8'(i + 1)), $sformatf("min1_rise%0d", i));
        step1(0, 0, mk(1, 0, 1, 0, 8'(i + 1)), $sformatf("min1_hidle%0d", i));
      end else begin
        step1(0, 1, mk(0, 1, 0, 0, 8'(i + 1)), $sformatf("min1_fall%0d", i));
        step1(0, 0, mk(0, 0, 1, 0, 8'(i + 1)), $sformatf("min1_lidle%0d", i));
      end
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp_q.size(), exp1_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
